draw_layer_arbiter: RTL and testbench
=====================================

// Module: draw_layer_arbiter
// PURPOSE
//   Priority compositor for the VGA object drawers (frog, waterfall, logs, cars...). Each drawer
//   supplies drawing_request + rrrgggbb colour per pixel; this block selects the highest-priority
//   enabled requester and registers the final pixel colour. It also accumulates per-frame player
//   collisions for the game logic. It applies layer enable masks only on frame boundaries.
// PARAMETERS
//   N_LAYERS    4      number of drawer inputs; index 0 = highest priority
//   PLAYER_IDX  0      layer whose overlap with other layers counts as a collision
//   BG_RGB      8'h00  colour output when no enabled layer requests
// PORTS
//   CLK              in   1          pixel clock
//   RESETn           in   1          asynchronous, active-low reset
//   startOfFrame     in   1          1-cycle pulse at first pixel of each frame
//   draw_req         in   N_LAYERS   per-layer drawing_request
//   rgb_in           in   8*N_LAYERS per-layer colour, layer k at [8k+7:8k]
//   layer_en_next    in   N_LAYERS   requested enable mask
//   layer_en_load    in   1          capture layer_en_next into pending mask
//   mVGA_RGB         out  8          composited pixel colour
//   drawing_request  out  1          some enabled layer won this pixel
//   winner_idx       out  clog2(N)   index of winning layer (0 when none)
//   collision        out  N_LAYERS   bit k: player overlapped layer k in last full frame
//   collision_valid  out  1          1-cycle pulse when collision updates
// BEHAVIOUR
//   Reset: mVGA_RGB=BG_RGB, drawing_request=0, winner_idx=0, collision=0, collision_valid=0,
//     active mask=all 1s, pending mask=all 1s, accumulator=0, FSM=WAIT_SOF.
//   FSM: WAIT_SOF -> RUN on first startOfFrame; RUN stays until reset. In WAIT_SOF outputs hold
//     reset values (arbitration is inactive), and layer_en_load still updates the pending mask.
//   Arbitration (RUN): eff = draw_req & active_mask. Winner = lowest set index of eff.
//     Latency exactly 1 CLK: registered outputs reflect the inputs of the previous cycle.
//     eff==0 -> mVGA_RGB=BG_RGB, drawing_request=0, winner_idx=0.
//   Enable mask: layer_en_load=1 -> pending<=layer_en_next (last load before SOF wins).
//     On startOfFrame: active<=pending. Load and SOF in the same cycle -> layer_en_next goes to
//     both pending and active. The active mask is used for arbitration from the cycle after SOF.
//     The SOF cycle itself is arbitrated with the old mask.
//   Collision (RUN): hit[k] = eff[PLAYER_IDX] & eff[k] for k!=PLAYER_IDX; hit[PLAYER_IDX]=0.
//     The accumulator ORs in hit every cycle (sticky) and uses the active mask, so disabled
//     layers never collide.
//     On startOfFrame in RUN: collision<=accum|hit_this_cycle... no: collision<=accum (frame
//     just ended), accum<=hit_this_cycle (SOF pixel belongs to the new frame), collision_valid=1.
//     The first SOF (WAIT_SOF->RUN) clears accum and does not pulse collision_valid.
//   collision holds its value between updates. collision_valid is high for exactly 1 cycle per SOF.
//   Reset mid-frame: asynchronous return to the reset values. The partial frame is discarded.
//   No combinational path from inputs to outputs.
// TESTING
//   1 reset, SOF, draw_req=4'b0110, rgb1=8'h27, rgb2=8'hE0 -> next cycle mVGA_RGB=8'h27,
//     drawing_request=1, winner_idx=1.
//   2 draw_req=0 for a cycle -> mVGA_RGB=BG_RGB, drawing_request=0, winner_idx=0.
//   3 load layer_en_next=4'b1101 mid-frame, draw_req=4'b0110 -> winner 1 until the cycle after
//     the next SOF, then winner 2, rgb 8'hE0.
//   4 frame with draw_req=4'b0101 for 3 cycles, then SOF -> collision=4'b0100 and
//     collision_valid=1 for 1 cycle; following frame without overlap -> next SOF collision=0.
//   5 draw_req=4'b0011 in the SOF cycle itself -> the collision reported at that SOF excludes
//     bit 1; the next SOF reports 4'b0010.
//   6 assert RESETn=0 mid-frame with accum nonzero -> outputs at reset values immediately;
//     the first SOF after release gives no collision_valid pulse.

Source files
------------

// File: rtl/draw_layer_arbiter.sv
// draw_layer_arbiter
// Priority compositor for the VGA object drawers. Picks the highest-priority
// enabled drawer each pixel and registers its colour. Also accumulates, per
// frame, which layers the player layer overlapped. Layer enable masks take
// effect only on frame boundaries.
module draw_layer_arbiter #(
  parameter int unsigned N_LAYERS   = 4,
  parameter int unsigned PLAYER_IDX = 0,
  parameter logic [7:0]  BG_RGB     = 8'h00,
  localparam int unsigned IW = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1
) (
  input  logic                    CLK,
  input  logic                    RESETn,
  input  logic                    startOfFrame,
  input  logic [N_LAYERS-1:0]     draw_req,
  input  logic [8*N_LAYERS-1:0]   rgb_in,
  input  logic [N_LAYERS-1:0]     layer_en_next,
  input  logic                    layer_en_load,
  output logic [7:0]              mVGA_RGB,
  output logic                    drawing_request,
  output logic [IW-1:0]           winner_idx,
  output logic [N_LAYERS-1:0]     collision,
  output logic                    collision_valid
);

  // Every layer except the player can be hit by the player.
  localparam logic [N_LAYERS-1:0] NP_MASK =
    ~({{(N_LAYERS-1){1'b0}}, 1'b1} << PLAYER_IDX);

  typedef enum logic [0:0] {
    WAIT_SOF = 1'b0,
    RUN      = 1'b1
  } state_t;

  state_t              state_q;
  logic [N_LAYERS-1:0] active_q;
  logic [N_LAYERS-1:0] pend_q;
  logic [N_LAYERS-1:0] accum_q;
  logic [N_LAYERS-1:0] coll_q;
  logic                coll_valid_q;
  logic [7:0]          rgb_q;
  logic                dreq_q;
  logic [IW-1:0]       win_q;

  logic [N_LAYERS-1:0] eff_s;
  logic [N_LAYERS-1:0] hit_s;
  logic [N_LAYERS-1:0] sof_mask_s;
  logic [IW-1:0]       win_s;
  logic [7:0]          rgb_sel_s;
  logic                any_s;

  // Effective requests, priority winner (lowest index), collision hits and
  // the mask that becomes active at a frame start.
  always_comb begin
    eff_s = draw_req & active_q;
    win_s = {IW{1'b0}};
    for (int k = N_LAYERS - 1; k >= 0; k--) begin
      win_s = eff_s[k] ? IW'(k) : win_s;
    end
    any_s     = |eff_s;
    rgb_sel_s = rgb_in[{win_s, 3'b000} +: 8];
    hit_s     = eff_s & {N_LAYERS{eff_s[PLAYER_IDX]}} & NP_MASK;
    if (layer_en_load) begin
      sof_mask_s = layer_en_next;
    end else begin
      sof_mask_s = pend_q;
    end
  end

  // Frame FSM, mask staging, pixel output and collision accumulation.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q      <= WAIT_SOF;
      active_q     <= {N_LAYERS{1'b1}};
      pend_q       <= {N_LAYERS{1'b1}};
      accum_q      <= {N_LAYERS{1'b0}};
      coll_q       <= {N_LAYERS{1'b0}};
      coll_valid_q <= 1'b0;
      rgb_q        <= BG_RGB;
      dreq_q       <= 1'b0;
      win_q        <= {IW{1'b0}};
    end else begin
      if (layer_en_load) begin
        pend_q <= layer_en_next;
      end
      if (startOfFrame) begin
        active_q <= sof_mask_s;
      end
      case (state_q)
        WAIT_SOF: begin
          // Outputs keep their reset values until the first frame starts.
          coll_valid_q <= 1'b0;
          if (startOfFrame) begin
            state_q <= RUN;
            accum_q <= {N_LAYERS{1'b0}};
          end
        end
        RUN: begin
          rgb_q  <= any_s ? rgb_sel_s : BG_RGB;
          dreq_q <= any_s;
          win_q  <= win_s;
          if (startOfFrame) begin
            // The SOF pixel belongs to the new frame.
            coll_q       <= accum_q;
            accum_q      <= hit_s;
            coll_valid_q <= 1'b1;
          end else begin
            accum_q      <= accum_q | hit_s;
            coll_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= WAIT_SOF;
        end
      endcase
    end
  end

  assign mVGA_RGB        = rgb_q;
  assign drawing_request = dreq_q;
  assign winner_idx      = win_q;
  assign collision       = coll_q;
  assign collision_valid = coll_valid_q;

endmodule

// File: tb/tb_draw_layer_arbiter.sv
// Directed self-checking bench for draw_layer_arbiter.
module tb_draw_layer_arbiter;

  logic        CLK;
  logic        RESETn;
  logic        startOfFrame;
  logic [3:0]  draw_req;
  logic [31:0] rgb_in;
  logic [3:0]  layer_en_next;
  logic        layer_en_load;
  logic [7:0]  mVGA_RGB;
  logic        drawing_request;
  logic [1:0]  winner_idx;
  logic [3:0]  collision;
  logic        collision_valid;

  int n_checks;
  int n_errors;

  draw_layer_arbiter #(
    .N_LAYERS   (4),
    .PLAYER_IDX (0),
    .BG_RGB     (8'h00)
  ) dut (
    .CLK             (CLK),
    .RESETn          (RESETn),
    .startOfFrame    (startOfFrame),
    .draw_req        (draw_req),
    .rgb_in          (rgb_in),
    .layer_en_next   (layer_en_next),
    .layer_en_load   (layer_en_load),
    .mVGA_RGB        (mVGA_RGB),
    .drawing_request (drawing_request),
    .winner_idx      (winner_idx),
    .collision       (collision),
    .collision_valid (collision_valid)
  );

  // Pixel clock, period 10.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_pix(input string tag, input logic [7:0] rgb, input logic dr,
                           input logic [1:0] win);
    check({tag, ".rgb"}, {24'h0, mVGA_RGB}, {24'h0, rgb});
    check({tag, ".dreq"}, {31'h0, drawing_request}, {31'h0, dr});
    check({tag, ".win"}, {30'h0, winner_idx}, {30'h0, win});
  endtask

  task automatic check_coll(input string tag, input logic [3:0] coll, input logic cv);
    check({tag, ".coll"}, {28'h0, collision}, {28'h0, coll});
    check({tag, ".cv"}, {31'h0, collision_valid}, {31'h0, cv});
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    RESETn        = 1'b0;
    startOfFrame  = 1'b0;
    draw_req      = 4'b0000;
    rgb_in        = {8'h3C, 8'hE0, 8'h27, 8'h11};
    layer_en_next = 4'b0000;
    layer_en_load = 1'b0;
    tick();
    tick();
    check_pix("reset", 8'h00, 1'b0, 2'd0);
    check_coll("reset", 4'b0000, 1'b0);
    RESETn = 1'b1;
    tick();

    // 1: first SOF leaves outputs idle, then arbitration starts.
    startOfFrame = 1'b1;
    draw_req     = 4'b0110;
    tick();
    check_pix("t1_sof", 8'h00, 1'b0, 2'd0);
    check_coll("t1_sof", 4'b0000, 1'b0);
    startOfFrame = 1'b0;
    tick();
    check_pix("t1", 8'h27, 1'b1, 2'd1);

    // 2: no requests -> background.
    draw_req = 4'b0000;
    tick();
    check_pix("t2", 8'h00, 1'b0, 2'd0);

    // 3: mask load mid-frame takes effect only after the next SOF.
    draw_req      = 4'b0110;
    layer_en_next = 4'b1101;
    layer_en_load = 1'b1;
    tick();
    check_pix("t3_load", 8'h27, 1'b1, 2'd1);
    layer_en_load = 1'b0;
    tick();
    check_pix("t3_wait", 8'h27, 1'b1, 2'd1);
    startOfFrame = 1'b1;
    tick();
    check_pix("t3_sof", 8'h27, 1'b1, 2'd1);
    check_coll("t3_sof", 4'b0000, 1'b1);
    startOfFrame = 1'b0;
    tick();
    check_pix("t3_new", 8'hE0, 1'b1, 2'd2);
    check_coll("t3_new", 4'b0000, 1'b0);

    // 4: player overlaps layer 2 for three cycles.
    draw_req = 4'b0101;
    tick();
    check_pix("t4_pix", 8'h11, 1'b1, 2'd0);
    tick();
    tick();
    startOfFrame = 1'b1;
    draw_req     = 4'b0000;
    tick();
    check_coll("t4_sof", 4'b0100, 1'b1);
    startOfFrame = 1'b0;
    tick();
    check_coll("t4_hold", 4'b0100, 1'b0);
    // Layer 1 is disabled: overlap with it must not count. Re-enable all
    // layers for the following frame.
    draw_req      = 4'b0011;
    layer_en_next = 4'b1111;
    layer_en_load = 1'b1;
    tick();
    check_pix("t4_mask", 8'h11, 1'b1, 2'd0);
    layer_en_load = 1'b0;
    tick();
    startOfFrame = 1'b1;
    draw_req     = 4'b0000;
    tick();
    check_coll("t4_none", 4'b0000, 1'b1);
    startOfFrame = 1'b0;

    // 5: overlap in the SOF cycle belongs to the new frame.
    draw_req = 4'b0101;
    tick();
    startOfFrame = 1'b1;
    draw_req     = 4'b0011;
    tick();
    check_coll("t5_sof", 4'b0100, 1'b1);
    check_pix("t5_sof", 8'h11, 1'b1, 2'd0);
    startOfFrame = 1'b0;
    draw_req     = 4'b0000;
    tick();
    check_coll("t5_mid", 4'b0100, 1'b0);
    startOfFrame = 1'b1;
    tick();
    check_coll("t5_next", 4'b0010, 1'b1);
    startOfFrame = 1'b0;

    // 6: asynchronous reset mid-frame with accumulator nonzero.
    draw_req = 4'b0101;
    tick();
    draw_req = 4'b0110;
    tick();
    check_pix("t6_pre", 8'h27, 1'b1, 2'd1);
    #2;
    RESETn = 1'b0;
    #1;
    check_pix("t6_rst", 8'h00, 1'b0, 2'd0);
    check_coll("t6_rst", 4'b0000, 1'b0);
    #1;
    RESETn       = 1'b1;
    startOfFrame = 1'b1;
    draw_req     = 4'b0101;
    tick();
    check_coll("t6_sof1", 4'b0000, 1'b0);
    check_pix("t6_sof1", 8'h00, 1'b0, 2'd0);
    startOfFrame = 1'b0;
    draw_req     = 4'b0000;
    tick();
    // Load coinciding with SOF goes straight to the active mask.
    startOfFrame  = 1'b1;
    layer_en_next = 4'b1011;
    layer_en_load = 1'b1;
    tick();
    check_coll("t6_sof2", 4'b0000, 1'b1);
    startOfFrame  = 1'b0;
    layer_en_load = 1'b0;
    draw_req      = 4'b0100;
    tick();
    check_pix("t7_masked", 8'h00, 1'b0, 2'd0);
    draw_req = 4'b1100;
    tick();
    check_pix("t7_l3", 8'h3C, 1'b1, 2'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
